song_reader: RTL and testbench
==============================

Name: song_reader

Overview:
- Sequencer that drives the note-load side of the note player: it fetches (note, duration) entries for the selected song from an external synchronous song ROM.
- It issues one load_new_note pulse per entry, then waits for done_with_note before fetching the next entry.
- It reports song_done when the song ends.
- It sits between the top-level music controller and the note player, one per player.

Parameters:
- SONG_BITS, 2, width of song select; 2^SONG_BITS songs in ROM
- NOTE_IDX_BITS, 5, log2 of max entries per song (32)

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- play_enable  input  1  1 = run/fetch, 0 = pause
- song  input  SONG_BITS  song select, latched at song start
- note_done  input  1  done_with_note from the note player
- rom_addr  output  SONG_BITS+NOTE_IDX_BITS  {song_reg, note_idx}, combinational from registers
- rom_data  input  12  {note[11:6], duration[5:0]}; valid the cycle after rom_addr is presented
- note_to_load  output  6  note for the player, registered
- duration_to_load  output  6  duration in beats, registered
- load_new_note  output  1  one-cycle load strobe, registered
- song_done  output  1  one-cycle end-of-song pulse, registered

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high, named reset.
- Reset values: state=IDLE; note_idx=0; song_reg=0; note_to_load=0; duration_to_load=0; load_new_note=0; song_done=0.
- Reset mid-operation: returns to these values at the next edge, regardless of state; any pending note_done is dropped.
- FSM states: IDLE, FETCH, LOAD, WAIT_DONE, ADVANCE, DONE.
- IDLE:
  - If play_enable=1: song_reg<=song, note_idx<=0, go to FETCH.
  - Otherwise stay.
- FETCH: rom_addr is presented; go to LOAD unconditionally (ROM read latency is 1 cycle).
- LOAD: rom_data is valid this cycle.
  - If duration==0 (end-of-song terminator): go to DONE; no load strobe.
  - Otherwise: note_to_load/duration_to_load <= rom_data fields, load_new_note<=1, go to WAIT_DONE.
- WAIT_DONE:
  - load_new_note is high only in the first WAIT_DONE cycle (exactly one cycle per note).
  - On note_done=1, go to ADVANCE.
  - note_done is accepted whether or not play_enable is high, so no completion is lost during pause.
- ADVANCE:
  - If note_idx == 2^NOTE_IDX_BITS-1: go to DONE.
  - Else if play_enable=1: note_idx<=note_idx+1, go to FETCH.
  - Else hold in ADVANCE (pause between notes).
- DONE: song_done=1 for exactly one cycle; note_idx<=0; go to IDLE.
- Song looping: if play_enable is still 1 in IDLE, the song restarts, re-latching song. Stopping is the controller's job.
- Latency: play_enable sampled high in IDLE at edge E → load_new_note high in the cycle after edge E+2.
  - Between notes: note_done sampled at edge N → next load_new_note high after edge N+3.
- Output hold: note_to_load/duration_to_load hold their last values until the next LOAD; they are not cleared by DONE.
- note_done outside WAIT_DONE: ignored.
- Song change: changes on song mid-song are ignored until the next IDLE→FETCH.
- Index: note_idx never wraps silently; the last index always goes through DONE.
- Pause points: play_enable=0 pauses only at IDLE and ADVANCE. FETCH and LOAD always complete (2 cycles), so a ROM read is never abandoned.

Test Plan:
- Basic load: reset 2 cycles; ROM song 0 entry0={note 1, dur 2}, entry1={dur 0}; song=0, play_enable=1 → rom_addr=0 in FETCH; load_new_note high exactly 1 cycle with note_to_load=1, duration_to_load=2.
- Handshake and end: pulse note_done 1 cycle → rom_addr=1, no second load strobe, song_done high exactly 1 cycle, then IDLE and restart at rom_addr=0.
- Pause between notes: 3-note song; drop play_enable in WAIT_DONE, pulse note_done → FSM holds in ADVANCE with rom_addr unchanged. Raise play_enable → next load 3 cycles later with entry1 values.
- Full-length song: song=2, all 32 entries nonzero duration, note_done after each load → 32 load strobes, rom_addr 64..95, song_done after the 32nd note_done; no wrap to index 0 before DONE.
- Mid-song changes: change song 0→1 during WAIT_DONE → subsequent rom_addr keep MSBs=0. Assert reset during WAIT_DONE → next cycle all outputs 0, state IDLE.
- Spurious done: note_done asserted during IDLE and FETCH → no state advance, no extra load_new_note.

Source files
------------

// File: rtl/song_reader.sv
// song_reader: fetches (note, duration) entries of the selected song from a
// synchronous song ROM and hands them one at a time to the note player.
// Each entry produces one load_new_note strobe. The next entry is fetched only
// after the player reports done_with_note. A zero-duration entry, or the last
// slot of the song, ends the song with a one-cycle song_done pulse.
module song_reader #(
    parameter int SONG_BITS     = 2,
    parameter int NOTE_IDX_BITS = 5
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               play_enable,
    input  logic [SONG_BITS-1:0]               song,
    input  logic                               note_done,
    output logic [SONG_BITS+NOTE_IDX_BITS-1:0] rom_addr,
    input  logic [11:0]                        rom_data,
    output logic [5:0]                         note_to_load,
    output logic [5:0]                         duration_to_load,
    output logic                               load_new_note,
    output logic                               song_done
);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LOAD,
        WAIT_DONE,
        ADVANCE,
        DONE
    } state_t;

    // Highest entry index of a song. Reaching it always ends the song, so the
    // index can never wrap back to entry 0 on its own.
    localparam logic [NOTE_IDX_BITS-1:0] LAST_IDX = '1;

    state_t                     state;
    logic [SONG_BITS-1:0]       song_reg;
    logic [NOTE_IDX_BITS-1:0]   note_idx;

    // ROM entry fields: note in the upper six bits, duration in beats below.
    logic [5:0] rom_note;
    logic [5:0] rom_duration;

    assign rom_note     = rom_data[11:6];
    assign rom_duration = rom_data[5:0];

    // The ROM address is driven straight from registers. It is therefore
    // stable for the whole FETCH cycle, and the ROM returns the entry in LOAD.
    assign rom_addr = {song_reg, note_idx};

    // Sequencer FSM with registered strobes and note/duration holding registers.
    always_ff @(posedge clk) begin
        // NOTE: every register in this block uses <=, so all next-state terms
        // read the values from before this edge, whatever the statement order.
        if (reset) begin
            // NOTE: reset is sampled on the clock edge, so it is written as a
            // branch inside the clocked block rather than in the sensitivity list.
            state            <= IDLE;
            song_reg         <= '0;
            note_idx         <= '0;
            note_to_load     <= '0;
            duration_to_load <= '0;
            load_new_note    <= 1'b0;
            song_done        <= 1'b0;
        end else begin
            // Both strobes default low, so each stays high for a single cycle.
            load_new_note <= 1'b0;
            song_done     <= 1'b0;

            case (state)
                IDLE: begin
                    // The song select is captured only here. Changes made
                    // mid-song take effect on the next pass through IDLE.
                    if (play_enable) begin
                        song_reg <= song;
                        note_idx <= '0;
                        state    <= FETCH;
                    end
                end

                FETCH: begin
                    // The address is on the ROM during this cycle. The read
                    // always completes, even if play_enable drops.
                    state <= LOAD;
                end

                LOAD: begin
                    if (rom_duration == 6'd0) begin
                        // Terminator entry: end the song without loading it.
                        song_done <= 1'b1;
                        state     <= DONE;
                    end else begin
                        note_to_load     <= rom_note;
                        duration_to_load <= rom_duration;
                        load_new_note    <= 1'b1;
                        state            <= WAIT_DONE;
                    end
                end

                WAIT_DONE: begin
                    // Completion is accepted even while paused, so a note
                    // that finishes during a pause is not lost.
                    if (note_done) begin
                        state <= ADVANCE;
                    end
                end

                ADVANCE: begin
                    if (note_idx == LAST_IDX) begin
                        song_done <= 1'b1;
                        state     <= DONE;
                    end else if (play_enable) begin
                        note_idx <= note_idx + 1'b1;
                        state    <= FETCH;
                    end
                end

                DONE: begin
                    // song_done was raised on entry to this state. The
                    // note/duration registers keep their last values.
                    note_idx <= '0;
                    state    <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_song_reader.sv
// tb_song_reader: directed bench for song_reader. It uses a behavioural
// synchronous song ROM. Expected load/done events go into a scoreboard queue,
// and a negedge monitor pops and compares them as the DUT produces strobes.
module tb_song_reader;

    logic        clk;
    logic        reset;
    logic        play_enable;
    logic [1:0]  song;
    logic        note_done;
    logic [6:0]  rom_addr;
    logic [11:0] rom_data;
    logic [5:0]  note_to_load;
    logic [5:0]  duration_to_load;
    logic        load_new_note;
    logic        song_done;

    typedef struct {
        bit         is_done;
        logic [5:0] note;
        logic [5:0] dur;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    logic [11:0] rom [0:127];
    logic prev_load = 1'b0;

    song_reader #(.SONG_BITS(2), .NOTE_IDX_BITS(5)) dut (
        .clk              (clk),
        .reset            (reset),
        .play_enable      (play_enable),
        .song             (song),
        .note_done        (note_done),
        .rom_addr         (rom_addr),
        .rom_data         (rom_data),
        .note_to_load     (note_to_load),
        .duration_to_load (duration_to_load),
        .load_new_note    (load_new_note),
        .song_done        (song_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous ROM with one-cycle read latency.
    always @(posedge clk) rom_data <= rom[rom_addr];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic push_load(input logic [5:0] note, input logic [5:0] dur);
        exp_t e;
        e.is_done = 1'b0;
        e.note    = note;
        e.dur     = dur;
        sb.push_back(e);
    endtask

    task automatic push_done();
        exp_t e;
        e.is_done = 1'b1;
        e.note    = '0;
        e.dur     = '0;
        sb.push_back(e);
    endtask

    task automatic pulse_done();
        note_done = 1'b1;
        tick();
        note_done = 1'b0;
    endtask

    // Advance negedge by negedge until the strobe appears. The count returned
    // is the number of negedges taken. An expired bound is recorded as a failure.
    task automatic wait_sig(input string name, input bit want_done, input int max, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!(want_done ? song_done : load_new_note) && n < max);
        if (!(want_done ? song_done : load_new_note))
            check({name, "_timeout"}, want_done ? song_done : load_new_note, 1);
    endtask

    // Scoreboard monitor: every strobe must match the next expected event.
    always @(negedge clk) begin
        if (!reset) begin
            if (load_new_note) begin
                check("load_pulse_width", prev_load, 0);
                check("load_expected", sb.size() != 0, 1);
                if (sb.size() != 0) begin
                    exp_t e;
                    e = sb.pop_front();
                    check("load_kind", e.is_done, 0);
                    check("note_to_load", note_to_load, e.note);
                    check("duration_to_load", duration_to_load, e.dur);
                end
            end
            if (song_done) begin
                check("done_expected", sb.size() != 0, 1);
                if (sb.size() != 0) begin
                    exp_t e;
                    e = sb.pop_front();
                    check("done_kind", e.is_done, 1);
                end
            end
        end
        prev_load = load_new_note;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        for (int i = 0; i < 128; i++) rom[i] = 12'd0;
        // Song 0: one note, then the terminator.
        rom[0] = {6'd1, 6'd2};
        rom[1] = {6'd9, 6'd0};
        // Song 1: three notes, then the terminator.
        rom[32] = {6'd5, 6'd3};
        rom[33] = {6'd6, 6'd4};
        rom[34] = {6'd7, 6'd5};
        rom[35] = {6'd0, 6'd0};
        // Song 2: all 32 slots used.
        for (int i = 0; i < 32; i++) rom[64+i] = {6'(i + 10), 6'(i + 1)};

        reset = 1'b1; play_enable = 1'b0; song = 2'd0; note_done = 1'b0;
        repeat (2) tick();
        check("rst_rom_addr", rom_addr, 0);
        check("rst_note", note_to_load, 0);
        check("rst_dur", duration_to_load, 0);
        check("rst_load", load_new_note, 0);
        check("rst_done", song_done, 0);
        reset = 1'b0;
        repeat (3) tick();
        check("idle_hold_addr", rom_addr, 0);

        // Basic load of song 0, entry 0.
        push_load(6'd1, 6'd2);
        play_enable = 1'b1;
        tick();
        check("fetch_addr", rom_addr, 0);
        wait_sig("first_load", 1'b0, 10, n);
        check("start_latency", n, 2);
        tick();
        check("load_width", load_new_note, 0);

        // Handshake, terminator and automatic restart.
        push_done();
        pulse_done();
        tick();
        check("fetch_idx1", rom_addr, 1);
        wait_sig("song0_done", 1'b1, 10, n);
        check("done_latency", n, 2);
        push_load(6'd1, 6'd2);
        tick();
        check("done_width", song_done, 0);
        check("idle_addr", rom_addr, 0);
        tick();
        check("restart_addr", rom_addr, 0);
        wait_sig("restart_load", 1'b0, 10, n);
        check("restart_latency", n, 2);

        // Song select changed mid-song is ignored until the next start.
        song = 2'd1;
        tick();
        push_done();
        pulse_done();
        tick();
        check("song_hold_addr", rom_addr, 1);
        wait_sig("song0b_done", 1'b1, 10, n);
        play_enable = 1'b0;
        repeat (4) tick();
        check("stopped_idle_addr", rom_addr, 0);

        // Spurious note_done in IDLE and FETCH.
        note_done = 1'b1;
        repeat (3) tick();
        check("spurious_idle_addr", rom_addr, 0);
        push_load(6'd5, 6'd3);
        play_enable = 1'b1;
        tick();
        check("song1_fetch_addr", rom_addr, 32);
        tick();
        note_done = 1'b0;
        tick();
        check("song1_load", load_new_note, 1);
        repeat (3) tick();
        check("no_spurious_advance", rom_addr, 32);

        // Pause between notes: completion accepted while paused, hold in ADVANCE.
        play_enable = 1'b0;
        pulse_done();
        repeat (4) tick();
        check("pause_hold_addr", rom_addr, 32);
        check("pause_no_load", load_new_note, 0);
        push_load(6'd6, 6'd4);
        play_enable = 1'b1;
        wait_sig("resume_load", 1'b0, 10, n);
        check("resume_latency", n, 3);
        check("resume_addr", rom_addr, 33);
        push_load(6'd7, 6'd5);
        pulse_done();
        wait_sig("song1_note3", 1'b0, 10, n);
        check("between_note_latency", n, 3);
        push_done();
        pulse_done();
        wait_sig("song1_done", 1'b1, 10, n);
        play_enable = 1'b0;
        tick();

        // Full-length song 2: 32 notes, then done without wrapping.
        song = 2'd2;
        for (int i = 0; i < 32; i++) push_load(6'(i + 10), 6'(i + 1));
        push_done();
        play_enable = 1'b1;
        for (int i = 0; i < 32; i++) begin
            wait_sig("full_load", 1'b0, 12, n);
            check("full_addr", rom_addr, 64 + i);
            pulse_done();
        end
        wait_sig("full_done", 1'b1, 12, n);
        play_enable = 1'b0;
        check("last_done_latency", n, 1);
        check("no_wrap_addr", rom_addr, 95);
        tick();
        check("idle_after_full", rom_addr, 64);

        // Reset during WAIT_DONE with a pending note_done.
        push_load(6'd10, 6'd1);
        play_enable = 1'b1;
        wait_sig("pre_reset_load", 1'b0, 10, n);
        tick();
        reset = 1'b1;
        note_done = 1'b1;
        tick();
        check("mid_rst_addr", rom_addr, 0);
        check("mid_rst_note", note_to_load, 0);
        check("mid_rst_dur", duration_to_load, 0);
        check("mid_rst_load", load_new_note, 0);
        check("mid_rst_done", song_done, 0);
        reset = 1'b0;
        note_done = 1'b0;
        play_enable = 1'b0;
        repeat (4) tick();
        check("post_rst_idle_addr", rom_addr, 0);

        check("sb_drained", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
